// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13 block_id, R14 block size, R15 thread id.
// Optional build macro REGFILE_ZERO_R0_EN hardwires R0 to zero.
module thread_regfile #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_ID         = 0,
    parameter int unsigned DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic                 decoded_nzp_write_enable,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic [2:0]           nzp
);

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_LSU  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    localparam logic [1:0] MUX_NONE = 2'b11;

    localparam int unsigned NUM_GP = 13;
    localparam logic [3:0]  LAST_GP = 4'd12;

    localparam logic [DATA_BITS-1:0] R14_VALUE = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] R15_VALUE = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] gp_regs [NUM_GP];
    logic [DATA_BITS-1:0] r13;

    logic                 is_request;
    logic                 is_update;
    logic                 reg_write;
    logic                 nzp_write;
    logic                 rd_writable;
    logic [DATA_BITS-1:0] write_data;
    logic [DATA_BITS-1:0] rs_read;
    logic [DATA_BITS-1:0] rt_read;

    assign is_request = (core_state == CORE_REQUEST);
    assign is_update  = (core_state == CORE_UPDATE);

`ifdef REGFILE_ZERO_R0_EN
    assign rd_writable = (decoded_rd_address <= LAST_GP) && (decoded_rd_address != 4'd0);
`else
    assign rd_writable = (decoded_rd_address <= LAST_GP);
`endif

    // Writes to R13-R15 and mux code 11 are dropped rather than flagged.
    assign reg_write = is_update && decoded_reg_write_enable && rd_writable &&
                       (decoded_reg_input_mux != MUX_NONE);
    assign nzp_write = is_update && decoded_nzp_write_enable;

    always_comb begin
        write_data = '0;
        unique case (decoded_reg_input_mux)
            MUX_ALU:  write_data = alu_out;
            MUX_LSU:  write_data = lsu_out;
            MUX_IMM:  write_data = decoded_immediate;
            MUX_NONE: write_data = '0;
            default:  write_data = '0;
        endcase
    end

    // Reads use the stored R13, so a REQUEST sees block_id as of the previous edge.
    always_comb begin
        rs_read = '0;
        if (decoded_rs_address <= LAST_GP) begin
            rs_read = gp_regs[decoded_rs_address];
        end else if (decoded_rs_address == 4'd13) begin
            rs_read = r13;
        end else if (decoded_rs_address == 4'd14) begin
            rs_read = R14_VALUE;
        end else begin
            rs_read = R15_VALUE;
        end
`ifdef REGFILE_ZERO_R0_EN
        if (decoded_rs_address == 4'd0) begin
            rs_read = '0;
        end
`endif
    end

    always_comb begin
        rt_read = '0;
        if (decoded_rt_address <= LAST_GP) begin
            rt_read = gp_regs[decoded_rt_address];
        end else if (decoded_rt_address == 4'd13) begin
            rt_read = r13;
        end else if (decoded_rt_address == 4'd14) begin
            rt_read = R14_VALUE;
        end else begin
            rt_read = R15_VALUE;
        end
`ifdef REGFILE_ZERO_R0_EN
        if (decoded_rt_address == 4'd0) begin
            rt_read = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_GP); i++) begin
                gp_regs[i] <= '0;
            end
            r13 <= '0;
            rs  <= '0;
            rt  <= '0;
            nzp <= 3'b000;
        end else if (enable) begin
            r13 <= DATA_BITS'(block_id);
            if (is_request) begin
                rs <= rs_read;
                rt <= rt_read;
            end
            if (reg_write) begin
                gp_regs[decoded_rd_address] <= write_data;
            end
            if (nzp_write) begin
                nzp <= alu_out[2:0];
            end
        end
    end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile with THREADS_PER_BLOCK=4, THREAD_ID=2.
module tb_thread_regfile;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] rd_addr, rs_addr, rt_addr;
    logic       reg_we;
    logic [1:0] reg_mux;
    logic [7:0] imm;
    logic       nzp_we;
    logic [7:0] alu_out, lsu_out;
    logic [7:0] rs, rt;
    logic [2:0] nzp;

    int checks   = 0;
    int failures = 0;

    thread_regfile #(
        .THREADS_PER_BLOCK(4),
        .THREAD_ID        (2),
        .DATA_BITS        (8)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .enable                  (enable),
        .block_id                (block_id),
        .core_state              (core_state),
        .decoded_rd_address      (rd_addr),
        .decoded_rs_address      (rs_addr),
        .decoded_rt_address      (rt_addr),
        .decoded_reg_write_enable(reg_we),
        .decoded_reg_input_mux   (reg_mux),
        .decoded_immediate       (imm),
        .decoded_nzp_write_enable(nzp_we),
        .alu_out                 (alu_out),
        .lsu_out                 (lsu_out),
        .rs                      (rs),
        .rt                      (rt),
        .nzp                     (nzp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [3:0] rd, input logic [1:0] mux, input logic we,
                             input logic nwe, input logic [7:0] i, input logic [7:0] a,
                             input logic [7:0] l);
        rd_addr    = rd;
        reg_mux    = mux;
        reg_we     = we;
        nzp_we     = nwe;
        imm        = i;
        alu_out    = a;
        lsu_out    = l;
        core_state = ST_UPDATE;
        tick();
        core_state = ST_IDLE;
        reg_we     = 1'b0;
        nzp_we     = 1'b0;
    endtask

    task automatic do_request(input logic [3:0] a_rs, input logic [3:0] a_rt);
        rs_addr    = a_rs;
        rt_addr    = a_rt;
        core_state = ST_REQUEST;
        tick();
        core_state = ST_IDLE;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        block_id   = 8'h00;
        core_state = ST_IDLE;
        rd_addr    = 4'd0;
        rs_addr    = 4'd0;
        rt_addr    = 4'd0;
        reg_we     = 1'b0;
        reg_mux    = 2'b00;
        imm        = 8'h00;
        nzp_we     = 1'b0;
        alu_out    = 8'h00;
        lsu_out    = 8'h00;

        #3;
        check("reset_rs", rs, 8'h00);
        check("reset_rt", rt, 8'h00);
        check("reset_nzp", {5'b0, nzp}, 8'h00);
        tick();
        reset_n = 1'b1;

        do_request(4'd14, 4'd15);
        check("r14_block_size", rs, 8'h04);
        check("r15_thread_id", rt, 8'h02);
        check("nzp_after_reset", {5'b0, nzp}, 8'h00);

        do_update(4'd3, 2'b10, 1'b1, 1'b0, 8'h5A, 8'h00, 8'h00);
        do_request(4'd3, 4'd0);
        check("r3_imm", rs, 8'h5A);
        check("r0_untouched", rt, 8'h00);

        do_update(4'd3, 2'b00, 1'b1, 1'b0, 8'h00, 8'h11, 8'h00);
        do_request(4'd3, 4'd0);
        check("r3_alu", rs, 8'h11);

        do_update(4'd3, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, 8'hC3);
        do_request(4'd3, 4'd0);
        check("r3_lsu", rs, 8'hC3);

        // R13 write is discarded; R13 tracks block_id one edge late.
        block_id = 8'd7;
        do_update(4'd13, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        block_id = 8'd9;
        do_request(4'd13, 4'd13);
        check("r13_pre_edge", rs, 8'h07);
        do_request(4'd13, 4'd0);
        check("r13_follows_block", rs, 8'h09);

        do_update(4'd14, 2'b10, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        do_update(4'd15, 2'b10, 1'b1, 1'b0, 8'hEE, 8'h00, 8'h00);
        do_request(4'd14, 4'd15);
        check("r14_write_dropped", rs, 8'h04);
        check("r15_write_dropped", rt, 8'h02);

        do_update(4'd5, 2'b00, 1'b1, 1'b1, 8'h00, 8'h04, 8'h00);
        check("nzp_from_alu", {5'b0, nzp}, 8'h04);
        do_request(4'd5, 4'd3);
        check("r5_alu", rs, 8'h04);
        check("r3_still_c3", rt, 8'hC3);

        enable = 1'b0;
        do_update(4'd5, 2'b10, 1'b1, 1'b1, 8'h99, 8'h01, 8'h00);
        do_request(4'd3, 4'd14);
        check("disabled_rs_hold", rs, 8'h04);
        check("disabled_rt_hold", rt, 8'hC3);
        check("disabled_nzp_hold", {5'b0, nzp}, 8'h04);
        enable = 1'b1;
        do_request(4'd5, 4'd0);
        check("r5_kept", rs, 8'h04);

        do_update(4'd7, 2'b11, 1'b1, 1'b0, 8'hAA, 8'hAA, 8'hAA);
        do_request(4'd7, 4'd5);
        check("mux11_dropped", rs, 8'h00);

        rs_addr    = 4'd3;
        rt_addr    = 4'd14;
        core_state = ST_IDLE;
        tick();
        core_state = ST_UPDATE;
        tick();
        core_state = ST_IDLE;
        check("idle_rs_hold", rs, 8'h00);
        check("idle_rt_hold", rt, 8'h04);

        // Reset lands between edges while an UPDATE to R6 is pending and spans the next edge.
        do_request(4'd5, 4'd3);
        rd_addr    = 4'd6;
        reg_mux    = 2'b10;
        reg_we     = 1'b1;
        imm        = 8'h77;
        core_state = ST_UPDATE;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_rs", rs, 8'h00);
        check("midreset_rt", rt, 8'h00);
        check("midreset_nzp", {5'b0, nzp}, 8'h00);
        tick();
        reset_n    = 1'b1;
        core_state = ST_IDLE;
        reg_we     = 1'b0;
        do_request(4'd6, 4'd3);
        check("r6_abandoned", rs, 8'h00);
        check("r3_cleared", rt, 8'h00);

        do_update(4'd0, 2'b10, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00);
        do_request(4'd0, 4'd15);
`ifdef REGFILE_ZERO_R0_EN
        check("r0_hardwired", rs, 8'h00);
`else
        check("r0_writable", rs, 8'h33);
`endif
        check("r15_after_reset", rt, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
